// File: rtl/ew_fifo_pkg.sv
// Shared types and helpers for the read side of the RAM-backed synchronous FIFO.
package ew_fifo_pkg;

    localparam int STAGE_DEPTH = 2;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } stage_state_t;

    // Distance from b forward to a, with pointers carrying one wrap bit above the address.
    function automatic int unsigned ptr_diff(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned depth);
        return (a + 2 * depth - b) % (2 * depth);
    endfunction

endpackage

// File: rtl/ew_skid_buf2.sv
// Two-entry registered output stage; entry 0 is always the head presented downstream.
module ew_skid_buf2
    import ew_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  head_valid,
    output logic [1:0]            count
);

    stage_state_t          state_q, state_d;
    logic [DATA_WIDTH-1:0] ent0_p0, ent1_p1;
    logic                  ld0, ld0_from1, ld1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ld0       = 1'b0;
        ld0_from1 = 1'b0;
        ld1       = 1'b0;
        if (flush) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (push) begin
                        state_d = S_ONE;
                        ld0     = 1'b1;
                    end
                end
                S_ONE: begin
                    if (push && pop) begin
                        ld0 = 1'b1;
                    end else if (push) begin
                        state_d = S_TWO;
                        ld1     = 1'b1;
                    end else if (pop) begin
                        state_d = S_EMPTY;
                    end
                end
                // Full: the producer is held off, so only a pop can change anything.
                S_TWO: begin
                    if (pop) begin
                        state_d   = S_ONE;
                        ld0       = 1'b1;
                        ld0_from1 = 1'b1;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    // Stage boundary: entry registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent0_p0 <= '0;
            ent1_p1 <= '0;
        end else begin
            if (ld0) ent0_p0 <= ld0_from1 ? ent1_p1 : push_data;
            if (ld1) ent1_p1 <= push_data;
        end
    end

    always_comb begin
        count = 2'd0;
        case (state_q)
            S_ONE:   count = 2'd1;
            S_TWO:   count = 2'd2;
            default: count = 2'd0;
        endcase
    end

    assign head_data  = ent0_p0;
    assign head_valid = (state_q != S_EMPTY);

endmodule

// File: rtl/ew_ram_rd_ctrl.sv
// Read-side controller for the async-read DFF RAM: drains committed words into a
// registered valid/ready stream and returns the read pointer to the write side.
module ew_ram_rd_ctrl
    import ew_fifo_pkg::*;
#(
    parameter int  DATA_WIDTH = 32,
    parameter int  RAM_DEPTH  = 8,
    localparam int ADDR_WIDTH = $clog2(RAM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH:0]   wr_ptr,
    input  logic                  flush,
    output logic [ADDR_WIDTH:0]   rd_ptr,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  empty,
    output logic [ADDR_WIDTH+1:0] level
);

    localparam int PTR_W = ADDR_WIDTH + 1;
    localparam int LVL_W = ADDR_WIDTH + 2;

    logic       ram_avail;
    logic       fetch;
    logic       pop;
    logic [1:0] stage_cnt;

    assign ram_avail = (rd_ptr != wr_ptr);
    // Fetch is independent of m_ready so the RAM address never depends on the consumer.
    assign fetch     = ram_avail && (stage_cnt != 2'(STAGE_DEPTH)) && !flush;
    assign pop       = m_valid && m_ready;

    // Stage boundary: read pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
        end else if (fetch) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    assign ram_rd_addr = rd_ptr[ADDR_WIDTH-1:0];

    ew_skid_buf2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_stage (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .push       (fetch),
        .push_data  (ram_rd_data),
        .pop        (pop),
        .head_data  (m_data),
        .head_valid (m_valid),
        .count      (stage_cnt)
    );

    assign empty = ~m_valid;
    assign level = LVL_W'(ptr_diff(32'(wr_ptr), 32'(rd_ptr), RAM_DEPTH) + 32'(stage_cnt));

    a_wr_not_overrun: assert property (@(posedge clk) disable iff (rst)
        ptr_diff(32'(wr_ptr), 32'(rd_ptr), RAM_DEPTH) <= RAM_DEPTH);

endmodule

// File: tb/tb_ew_ram_rd_ctrl.sv
// Scoreboard bench for ew_ram_rd_ctrl with a behavioural RAM and writer.
module tb_ew_ram_rd_ctrl;

    localparam int DW = 32;
    localparam int DEPTH = 8;
    localparam int AW = 3;

    logic          clk;
    logic          rst;
    logic [AW:0]   wr_ptr;
    logic          flush;
    logic [AW:0]   rd_ptr;
    logic [AW-1:0] ram_rd_addr;
    logic [DW-1:0] ram_rd_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          empty;
    logic [AW+1:0] level;

    logic [DW-1:0] mem [DEPTH];
    assign ram_rd_data = mem[ram_rd_addr];

    ew_ram_rd_ctrl #(.DATA_WIDTH(DW), .RAM_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_ptr      (wr_ptr),
        .flush       (flush),
        .rd_ptr      (rd_ptr),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (ram_rd_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .empty       (empty),
        .level       (level)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Every word written and not yet consumed or discarded, oldest first,
    // tagged with the clock edge after which it became visible to the reader.
    typedef struct {
        logic [DW-1:0] data;
        int            wcyc;
    } ent_t;
    ent_t exp_q[$];

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: all stream-level checks happen on the falling edge.
    always @(negedge clk) begin
        logic exp_v;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            chk("level", 64'(level), 64'(exp_q.size()));
            chk("empty", 64'(empty), 64'(!m_valid));
            chk("rd_addr", 64'(ram_rd_addr), 64'(rd_ptr[AW-1:0]));
            exp_v = (exp_q.size() > 0) && (cyc > exp_q[0].wcyc);
            chk("m_valid", 64'(m_valid), 64'(exp_v));
            if (prev_stall) chk("hold_data", 64'(m_data), 64'(prev_data));
            if (m_valid && m_ready && exp_q.size() > 0) begin
                chk("m_data", 64'(m_data), 64'(exp_q[0].data));
                void'(exp_q.pop_front());
            end
            if (flush) exp_q.delete();
            prev_stall = m_valid && !m_ready && !flush;
            prev_data  = m_data;
        end
    end

    function automatic logic full_now();
        logic [AW:0] d;
        d = wr_ptr - rd_ptr;
        return (d == (AW+1)'(DEPTH));
    endfunction

    task automatic tick(input logic do_wr, input logic [DW-1:0] d,
                        input logic rdy, input logic fl);
        @(posedge clk);
        #1;
        if (do_wr) begin
            mem[wr_ptr[AW-1:0]] = d;
            wr_ptr = wr_ptr + 1'b1;
            exp_q.push_back('{data: d, wcyc: cyc});
        end
        m_ready = rdy;
        flush   = fl;
    endtask

    task automatic drain(input string name);
        repeat (12) tick(1'b0, '0, 1'b1, 1'b0);
        chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
        chk({name, "_ptr_eq"}, 64'(rd_ptr), 64'(wr_ptr));
    endtask

    initial begin
        logic [AW:0] base;
        logic [AW:0] e;
        logic        saw_wrap;
        rst = 1'b1;
        wr_ptr = '0;
        flush = 1'b0;
        m_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_rd_ptr", 64'(rd_ptr), 64'd0);
        chk("rst_m_data", 64'(m_data), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_level", 64'(level), 64'd0);
        rst = 1'b0;

        // Single word
        tick(1'b1, 32'hA5A5_A5A5, 1'b1, 1'b0);
        repeat (3) tick(1'b0, '0, 1'b1, 1'b0);
        chk("basic_rd_ptr", 64'(rd_ptr), 64'd1);
        chk("basic_empty", 64'(empty), 64'd1);

        // Back-pressure
        base = rd_ptr;
        for (int i = 1; i <= 3; i++) tick(1'b1, DW'(i), 1'b0, 1'b0);
        repeat (3) tick(1'b0, '0, 1'b0, 1'b0);
        e = base + (AW+1)'(2);
        chk("bp_rd_ptr", 64'(rd_ptr), 64'(e));
        chk("bp_level", 64'(level), 64'd3);
        chk("bp_m_data", 64'(m_data), 64'd1);
        drain("bp");

        // Continuous stream across the wrap
        base = rd_ptr;
        saw_wrap = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, $urandom, 1'b1, 1'b0);
            if (rd_ptr[AW] != base[AW]) saw_wrap = 1'b1;
        end
        drain("wrap");
        e = base + (AW+1)'(20);
        chk("wrap_rd_ptr", 64'(rd_ptr), 64'(e));
        chk("wrap_bit_seen", 64'(saw_wrap), 64'd1);

        // RAM full, consumer stalled
        base = rd_ptr;
        for (int i = 0; i < DEPTH; i++) tick(1'b1, $urandom, 1'b0, 1'b0);
        repeat (3) tick(1'b0, '0, 1'b0, 1'b0);
        e = base + (AW+1)'(2);
        chk("full_level", 64'(level), 64'(DEPTH));
        chk("full_rd_ptr", 64'(rd_ptr), 64'(e));
        drain("full");

        // Flush with pending words
        for (int i = 0; i < 5; i++) tick(1'b1, $urandom, 1'b0, 1'b0);
        repeat (2) tick(1'b0, '0, 1'b0, 1'b0);
        tick(1'b0, '0, 1'b0, 1'b1);
        tick(1'b0, '0, 1'b0, 1'b0);
        chk("flush_m_valid", 64'(m_valid), 64'd0);
        chk("flush_rd_ptr", 64'(rd_ptr), 64'(wr_ptr));
        chk("flush_level", 64'(level), 64'd0);
        tick(1'b1, 32'h1234_5678, 1'b1, 1'b0);
        drain("post_flush");

        // Asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) tick(1'b1, $urandom, 1'b0, 1'b0);
        repeat (2) tick(1'b0, '0, 1'b0, 1'b0);
        chk("pre_rst_valid", 64'(m_valid), 64'd1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_m_valid", 64'(m_valid), 64'd0);
        chk("arst_rd_ptr", 64'(rd_ptr), 64'd0);
        chk("arst_m_data", 64'(m_data), 64'd0);
        chk("arst_empty", 64'(empty), 64'd1);
        chk("arst_level", 64'(level), 64'(wr_ptr));
        exp_q.delete();
        wr_ptr = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(1'b1, 32'hCAFE_F00D, 1'b1, 1'b0);
        drain("post_rst");
        chk("post_rst_rd_ptr", 64'(rd_ptr), 64'd1);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            logic rdy, fl, wr;
            rdy = ($urandom_range(0, 3) != 0);
            fl  = ($urandom_range(0, 40) == 0);
            wr  = !fl && !full_now() && ($urandom_range(0, 2) != 0);
            tick(wr, $urandom, rdy, fl);
        end
        tick(1'b0, '0, 1'b1, 1'b0);
        drain("random");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
